// File: rtl/tap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tap_pkg
// Description : Shared constants for the TAP deck controller and TAP player:
//               controller state encodings and TAP pulse timing (in clocks).
// Revision    : 1.0 - initial release
// ============================================================================
package tap_pkg;

  // Deck controller state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR0  = 3'd1;
  localparam logic [2:0] ST_HDR1  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_PLAY  = 3'd4;
  localparam logic [2:0] ST_PAUSE = 3'd5;
  localparam logic [2:0] ST_END   = 3'd6;

  // Standard ROM-loader pulse timings at 3.5 MHz, shared with the player
  localparam int T_PILOT      = 2168;
  localparam int T_SYNC1      = 667;
  localparam int T_SYNC2      = 735;
  localparam int T_BIT0       = 855;
  localparam int T_BIT1       = 1710;
  localparam int N_PILOT_HDR  = 8063;
  localparam int N_PILOT_DATA = 3223;

  // Tape motor runs whenever the deck is actively walking the image
  function automatic logic motor_on(input logic [2:0] st);
    return (st == ST_HDR0) || (st == ST_HDR1) || (st == ST_CHECK) ||
           (st == ST_PLAY) || (st == ST_PAUSE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tap_pause_timer.sv
`default_nettype none
// ============================================================================
// Module      : tap_pause_timer
// Description : Loadable down-counter timing the silence between tape blocks.
//               Load wins over count; counting stops at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tap_pause_timer #(
  parameter int CNT_W = 22
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_value,
  input  logic             i_enable,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Load a new pause length or count down towards zero
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/tap_deck_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tap_deck_ctrl
// Description : TAP tape-deck controller. Arbitrates the tape RAM between the
//               host loader and the player, walks the image block by block
//               via the 2-byte length headers, gates the player's play input,
//               inserts inter-block pauses and handles play/stop/rewind keys.
// Revision    : 1.0 - initial release
// ============================================================================
module tap_deck_ctrl
  import tap_pkg::*;
#(
  parameter int PAUSE_CYCLES = 3500000,
  parameter int CNT_W        = 22
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        key_play,
  input  logic        key_stop,
  input  logic        key_rewind,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_data,
  input  logic        host_len_we,
  input  logic [15:0] host_len,
  output logic        host_ready,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic [15:0] player_addr,
  output logic [7:0]  player_data,
  output logic        player_play,
  output logic        player_rst_n,
  output logic        motor,
  output logic [7:0]  block_num,
  output logic        at_end,
  output logic        err_trunc
);

  localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);

  logic [2:0]  r_state;
  logic [15:0] r_cur_block;
  logic [15:0] r_image_len;
  logic [15:0] r_blk_end;
  logic [15:0] r_len;
  logic [7:0]  r_block_num;
  logic        r_stop_pend;
  logic        r_err_trunc;
  logic        r_rst_pulse;

  logic        w_len_load;
  logic        w_blk_done;
  logic        w_stop_now;
  logic        w_pause_load;
  logic        w_pause_zero;
  logic [16:0] w_hdr_next;
  logic [16:0] w_blk_e;

  // Host owns the RAM only while the deck is parked
  assign host_ready = (r_state == ST_IDLE) || (r_state == ST_END);
  assign mem_we     = host_we & host_ready;
  assign mem_wdata  = host_data;
  assign w_len_load = host_len_we & host_ready;

  // Header/end arithmetic kept 17-bit so an overrun past 0xFFFF is still seen
  assign w_hdr_next = {1'b0, r_cur_block} + 17'd2;
  assign w_blk_e    = w_hdr_next + {1'b0, r_len};

  assign w_blk_done   = (r_state == ST_PLAY) && (player_addr == r_blk_end);
  assign w_stop_now   = r_stop_pend | key_stop;
  assign w_pause_load = w_blk_done && !key_rewind && !w_stop_now &&
                        (r_blk_end < r_image_len);

  // RAM address mux: host when parked, header bytes while parsing, else player
  always_comb begin
    mem_addr = player_addr;
    case (r_state)
      ST_IDLE, ST_END: mem_addr = host_addr;
      ST_HDR0:         mem_addr = r_cur_block;
      ST_HDR1:         mem_addr = r_cur_block + 16'd1;
      default:         mem_addr = player_addr;
    endcase
  end

  assign player_data  = mem_rdata;
  // Combinational so play drops the very cycle the player reaches the block end
  assign player_play  = (r_state == ST_PLAY) && (player_addr != r_blk_end);
  assign player_rst_n = reset_n & ~r_rst_pulse;
  assign motor        = motor_on(r_state);
  assign at_end       = (r_state == ST_END);
  assign block_num    = r_block_num;
  assign err_trunc    = r_err_trunc;

  tap_pause_timer #(
    .CNT_W (CNT_W)
  ) u_pause_timer (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_load       (w_pause_load),
    .i_load_value (PAUSE_LOAD),
    .i_enable     (r_state == ST_PAUSE),
    .o_zero       (w_pause_zero)
  );

  // Deck sequencer: rewind > new image > stop > play
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cur_block <= '0;
      r_image_len <= '0;
      r_blk_end   <= '0;
      r_len       <= '0;
      r_block_num <= '0;
      r_stop_pend <= 1'b0;
      r_err_trunc <= 1'b0;
      r_rst_pulse <= 1'b0;
    end else begin
      r_rst_pulse <= 1'b0;
      if (key_rewind || w_len_load) begin
        // Rewinding also resets the player so its address realigns with 0
        if (!key_rewind) begin
          r_image_len <= host_len;
        end
        r_rst_pulse <= 1'b1;
        r_cur_block <= '0;
        r_block_num <= '0;
        r_stop_pend <= 1'b0;
        r_err_trunc <= 1'b0;
        r_state     <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (key_play) begin
              r_state <= (r_cur_block >= r_image_len) ? ST_END : ST_HDR0;
            end
          end
          ST_HDR0: begin
            if (key_stop) r_stop_pend <= 1'b1;
            r_len[7:0] <= mem_rdata;
            r_state    <= ST_HDR1;
          end
          ST_HDR1: begin
            if (key_stop) r_stop_pend <= 1'b1;
            r_len[15:8] <= mem_rdata;
            r_state     <= ST_CHECK;
          end
          ST_CHECK: begin
            if (key_stop) r_stop_pend <= 1'b1;
            if (r_len == 16'd0) begin
              // Empty block: skip its header and carry on
              r_cur_block <= w_hdr_next[15:0];
              r_state     <= (w_hdr_next >= {1'b0, r_image_len}) ? ST_END : ST_HDR0;
            end else if (w_blk_e > {1'b0, r_image_len}) begin
              r_err_trunc <= 1'b1;
              r_state     <= ST_END;
            end else begin
              r_blk_end <= w_blk_e[15:0];
              r_state   <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (w_blk_done) begin
              r_cur_block <= r_blk_end;
              r_block_num <= r_block_num + 8'd1;
              if (w_stop_now) begin
                r_stop_pend <= 1'b0;
                r_state     <= ST_IDLE;
              end else if (r_blk_end >= r_image_len) begin
                r_state <= ST_END;
              end else begin
                r_state <= ST_PAUSE;
              end
            end else if (key_stop) begin
              r_stop_pend <= 1'b1;
            end
          end
          ST_PAUSE: begin
            if (key_stop) begin
              r_stop_pend <= 1'b0;
              r_state     <= ST_IDLE;
            end else if (w_pause_zero) begin
              r_state <= ST_HDR0;
            end
          end
          ST_END: begin
            r_state <= ST_END;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tap_deck_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tap_deck_ctrl
// Description : Directed self-checking bench for tap_deck_ctrl with a RAM
//               model and a simple player that advances one byte per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tap_deck_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        key_play, key_stop, key_rewind;
  logic        host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_data;
  logic        host_len_we;
  logic [15:0] host_len;
  logic        host_ready;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [15:0] player_addr;
  logic [7:0]  player_data;
  logic        player_play;
  logic        player_rst_n;
  logic        motor;
  logic [7:0]  block_num;
  logic        at_end;
  logic        err_trunc;

  int n_checks = 0;
  int n_errors = 0;
  logic last_prev;
  logic seen_play;
  logic seen_motor_low;
  int   cnt;

  logic [7:0] ram [0:65535];

  always #5 clock = ~clock;

  tap_deck_ctrl #(
    .PAUSE_CYCLES (100),
    .CNT_W        (22)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .key_play     (key_play),
    .key_stop     (key_stop),
    .key_rewind   (key_rewind),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_data    (host_data),
    .host_len_we  (host_len_we),
    .host_len     (host_len),
    .host_ready   (host_ready),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .player_addr  (player_addr),
    .player_data  (player_data),
    .player_play  (player_play),
    .player_rst_n (player_rst_n),
    .motor        (motor),
    .block_num    (block_num),
    .at_end       (at_end),
    .err_trunc    (err_trunc)
  );

  // RAM model: synchronous write, asynchronous read
  always @(posedge clock) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  // Player model: one byte per clock while play is high
  always @(posedge clock) begin
    if (!player_rst_n)    player_addr <= 16'd0;
    else if (player_play) player_addr <= player_addr + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_data = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic set_len(input logic [15:0] l);
    host_len_we = 1'b1; host_len = l;
    tick();
    host_len_we = 1'b0;
  endtask

  task automatic pulse_play();
    key_play = 1'b1;
    tick();
    key_play = 1'b0;
  endtask

  // Advance until the player reaches target; last_prev holds play one cycle earlier
  task automatic run_to(input logic [15:0] target, input string tag);
    int n = 0;
    logic prev = 1'b0;
    while (player_addr != target && n < 2000) begin
      prev = player_play;
      tick();
      n++;
    end
    chk({tag, "_reach"}, {31'd0, player_addr == target}, 32'd1);
    last_prev = prev;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    reset_n = 1'b0; key_play = 1'b0; key_stop = 1'b0; key_rewind = 1'b0;
    host_we = 1'b0; host_addr = 16'd0; host_data = 8'd0;
    host_len_we = 1'b0; host_len = 16'd0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_host_ready", host_ready, 1);
    chk("rst_motor", motor, 0);
    chk("rst_at_end", at_end, 0);
    chk("rst_play", player_play, 0);
    chk("rst_player_rst_n", player_rst_n, 0);
    chk("rst_block_num", block_num, 0);
    chk("rst_err", err_trunc, 0);
    reset_n = 1'b1;
    tick();
    chk("rst_release_prst", player_rst_n, 1);

    // ---- Test 1: blocks of 19 and 4 bytes, image_len 27 ----
    host_wr(16'd0, 8'h13); host_wr(16'd1, 8'h00);
    host_wr(16'd21, 8'h04); host_wr(16'd22, 8'h00);
    set_len(16'd27);
    chk("t1_len_rst_pulse", player_rst_n, 0);
    tick();
    chk("t1_len_rst_pulse_end", player_rst_n, 1);
    pulse_play();
    chk("t1_hdr0_addr", mem_addr, 16'd0);
    chk("t1_hdr0_motor", motor, 1);
    chk("t1_hdr0_ready", host_ready, 0);
    tick();
    chk("t1_hdr1_addr", mem_addr, 16'd1);
    tick(); tick();
    chk("t1_play_start", player_play, 1);
    run_to(16'd21, "t1_b0");
    chk("t1_b0_prev_play", last_prev, 1);
    chk("t1_b0_play_fall", player_play, 0);
    cnt = 0; seen_play = 1'b0; seen_motor_low = 1'b0;
    while (mem_addr != 16'd22 && cnt < 1000) begin
      if (player_play) seen_play = 1'b1;
      if (!motor)      seen_motor_low = 1'b1;
      tick();
      cnt++;
    end
    chk("t1_pause_len", cnt, 102);
    chk("t1_pause_noplay", seen_play, 0);
    chk("t1_motor_held", seen_motor_low, 0);
    chk("t1_blocknum_1", block_num, 1);
    tick(); tick();
    chk("t1_b1_play", player_play, 1);
    run_to(16'd27, "t1_b1");
    chk("t1_b1_prev_play", last_prev, 1);
    chk("t1_b1_play_fall", player_play, 0);
    tick();
    chk("t1_at_end", at_end, 1);
    chk("t1_blocknum_2", block_num, 2);
    chk("t1_end_motor", motor, 0);
    chk("t1_end_ready", host_ready, 1);
    pulse_play();
    chk("t1_end_ignores_play", at_end, 1);

    // ---- Test 2: zero-length block then a 3-byte block, image_len 7 ----
    host_wr(16'd0, 8'h00); host_wr(16'd1, 8'h00);
    host_wr(16'd2, 8'h03); host_wr(16'd3, 8'h00);
    set_len(16'd7);
    tick();
    chk("t2_idle_after_len", at_end, 0);
    chk("t2_blocknum_clr", block_num, 0);
    pulse_play();
    seen_play = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (player_play) seen_play = 1'b1;
      if (i == 4) chk("t2_skip_hdr_addr", mem_addr, 16'd2);
      if (i < 6) tick();
    end
    chk("t2_noplay_zero_blk", seen_play, 0);
    tick();
    chk("t2_play", player_play, 1);
    run_to(16'd7, "t2_b");
    chk("t2_play_fall", player_play, 0);
    tick();
    chk("t2_at_end", at_end, 1);
    chk("t2_blocknum", block_num, 1);

    // ---- Test 3: header length 0x0100 overruns image_len 50 ----
    host_wr(16'd0, 8'h00); host_wr(16'd1, 8'h01);
    set_len(16'd50);
    tick();
    pulse_play();
    seen_play = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (player_play) seen_play = 1'b1;
      tick();
    end
    chk("t3_noplay", seen_play | player_play, 0);
    chk("t3_at_end", at_end, 1);
    chk("t3_err_trunc", err_trunc, 1);
    chk("t3_blocknum", block_num, 0);

    // ---- Test 4/6: stop mid-block, host write blocked during PLAY ----
    host_wr(16'd0, 8'h13); host_wr(16'd1, 8'h00);
    set_len(16'd27);
    chk("t4_err_cleared", err_trunc, 0);
    tick();
    pulse_play();
    tick(); tick(); tick();
    run_to(16'd5, "t4_mid");
    host_we = 1'b1; host_addr = 16'd5; host_data = 8'hA5;
    #1;
    chk("t6_ready_play", host_ready, 0);
    chk("t6_mem_we_play", mem_we, 0);
    tick();
    host_we = 1'b0;
    chk("t6_ram_unchanged", ram[5], 8'h00);
    key_stop = 1'b1;
    tick();
    key_stop = 1'b0;
    chk("t4_still_playing", player_play, 1);
    run_to(16'd21, "t4_b0");
    chk("t4_play_fall", player_play, 0);
    tick();
    chk("t4_idle_ready", host_ready, 1);
    chk("t4_idle_motor", motor, 0);
    chk("t4_idle_at_end", at_end, 0);
    chk("t4_blocknum", block_num, 1);
    tick(); tick();
    chk("t4_stays_idle", host_ready, 1);
    host_wr(16'd5, 8'hA5);
    chk("t6_ram_written", ram[5], 8'hA5);
    pulse_play();
    chk("t4_resume_hdr0", mem_addr, 16'd21);
    tick();
    chk("t4_resume_hdr1", mem_addr, 16'd22);
    tick(); tick();
    chk("t4_resume_play", player_play, 1);

    // ---- Test 5: rewind together with play mid-block ----
    run_to(16'd24, "t5_mid");
    key_rewind = 1'b1; key_play = 1'b1;
    tick();
    key_rewind = 1'b0; key_play = 1'b0;
    chk("t5_prst_low", player_rst_n, 0);
    chk("t5_idle", host_ready, 1);
    chk("t5_blocknum", block_num, 0);
    chk("t5_motor", motor, 0);
    tick();
    chk("t5_prst_high", player_rst_n, 1);
    chk("t5_paddr_zero", player_addr, 16'd0);
    chk("t5_still_idle", host_ready, 1);
    pulse_play();
    chk("t5_hdr0_from_0", mem_addr, 16'd0);
    tick();
    chk("t5_hdr1_from_0", mem_addr, 16'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
